// File: rtl/sa1_pkg.sv
// Shared constants for the SA-1 Super MMC address map: register offsets,
// field positions and reset values.
package sa1_pkg;

  localparam logic [15:0] CXB_OFS   = 16'h0000;
  localparam logic [15:0] DXB_OFS   = 16'h0001;
  localparam logic [15:0] EXB_OFS   = 16'h0002;
  localparam logic [15:0] FXB_OFS   = 16'h0003;
  localparam logic [15:0] BMAPS_OFS = 16'h0004;
  localparam logic [15:0] SWEN_OFS  = 16'h0006;
  localparam logic [15:0] BWPA_OFS  = 16'h0008;

  localparam int unsigned MODE_BIT = 7;
  localparam int unsigned SWEN_BIT = 7;

  localparam logic [23:0] BWRAM_BASE = 24'hE00000;

  // Window k maps to 1 MB bank k out of reset, mode bit clear.
  function automatic logic [7:0] xxb_reset(input int unsigned k);
    return 8'(k);
  endfunction

endpackage

// File: rtl/sa1_mmc_regs.sv
// Shadow copies of the SA-1 MMC/BW-RAM mapping registers, snooped from SNES
// writes to banks 00-3F/80-BF.
module sa1_mmc_regs
  import sa1_pkg::*;
#(
  parameter int unsigned SBM_W    = 5,
  parameter int unsigned BWPA_W   = 4,
  parameter logic [15:0] REG_BASE = 16'h2220
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [23:0]       addr_i,
  input  logic [7:0]        data_i,
  input  logic              wr_i,
  output logic [31:0]       xxb_o,
  output logic [SBM_W-1:0]  sbm_o,
  output logic              swen_o,
  output logic [BWPA_W-1:0] bwpa_o
);

  logic [3:0][7:0]   xxb_q, xxb_d;
  logic [SBM_W-1:0]  sbm_q, sbm_d;
  logic              swen_q, swen_d;
  logic [BWPA_W-1:0] bwpa_q, bwpa_d;
  logic              sel;

  assign sel = wr_i & ~addr_i[22];

  always_comb begin
    xxb_d  = xxb_q;
    sbm_d  = sbm_q;
    swen_d = swen_q;
    bwpa_d = bwpa_q;
    if (sel) begin
      for (int k = 0; k < 4; k++) begin
        if (addr_i[15:0] == REG_BASE + CXB_OFS + 16'(k)) xxb_d[k] = data_i;
      end
      if (addr_i[15:0] == REG_BASE + BMAPS_OFS) sbm_d  = data_i[SBM_W-1:0];
      if (addr_i[15:0] == REG_BASE + SWEN_OFS)  swen_d = data_i[SWEN_BIT];
      if (addr_i[15:0] == REG_BASE + BWPA_OFS)  bwpa_d = data_i[BWPA_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < 4; k++) xxb_q[k] <= xxb_reset(k);
      sbm_q  <= '0;
      swen_q <= 1'b0;
      bwpa_q <= '0;
    end else begin
      xxb_q  <= xxb_d;
      sbm_q  <= sbm_d;
      swen_q <= swen_d;
      bwpa_q <= bwpa_d;
    end
  end

  assign xxb_o  = xxb_q;
  assign sbm_o  = sbm_q;
  assign swen_o = swen_q;
  assign bwpa_o = bwpa_q;

endmodule

// File: rtl/sa1_mmc_address.sv
// SA-1 address translation: Super MMC ROM windows, BW-RAM paging and write
// protection, registered one cycle after each lookup strobe.
module sa1_mmc_address
  import sa1_pkg::*;
#(
  parameter int unsigned ROM_BANK_W = 3,
  parameter int unsigned SBM_W      = 5,
  parameter int unsigned BWPA_W     = 4,
  parameter logic [15:0] REG_BASE   = 16'h2220
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [23:0] SNES_ADDR,
  input  logic        req_valid,
  input  logic [7:0]  SNES_DATA,
  input  logic        wr_stb,
  input  logic [23:0] SAVERAM_MASK,
  input  logic [23:0] ROM_MASK,
  output logic [23:0] ROM_ADDR,
  output logic        ROM_HIT,
  output logic        IS_ROM,
  output logic        IS_SAVERAM,
  output logic        IS_WRITABLE,
  output logic        out_valid
);

  // Wide enough that 256 << bwpa never overflows; off >= limit then saturates.
  localparam int unsigned LimW = 33 + (2 ** BWPA_W);

  logic [31:0]       xxb_flat;
  logic [3:0][7:0]   xxb;
  logic [SBM_W-1:0]  sbm;
  logic              swen;
  logic [BWPA_W-1:0] bwpa;

  sa1_mmc_regs #(
    .SBM_W   (SBM_W),
    .BWPA_W  (BWPA_W),
    .REG_BASE(REG_BASE)
  ) u_regs (
    .clk_i (CLK),
    .rst_ni(RST_N),
    .addr_i(SNES_ADDR),
    .data_i(SNES_DATA),
    .wr_i  (wr_stb),
    .xxb_o (xxb_flat),
    .sbm_o (sbm),
    .swen_o(swen),
    .bwpa_o(bwpa)
  );

  assign xxb = xxb_flat;

  logic                  lorom, hirom;
  logic [1:0]            k;
  logic [ROM_BANK_W-1:0] bank;
  logic [23:0]           off;
  logic [LimW-1:0]       limit;
  logic [23:0]           rom_addr_d, rom_addr_q;
  logic                  is_rom_d, is_rom_q;
  logic                  is_sram_d, is_sram_q;
  logic                  writable_d, writable_q;
  logic                  out_valid_q;

  always_comb begin
    lorom     = ~SNES_ADDR[22] & SNES_ADDR[15];
    hirom     = SNES_ADDR[23] & SNES_ADDR[22];
    is_rom_d  = lorom | hirom;
    is_sram_d = SAVERAM_MASK[0] & ((SNES_ADDR[23:20] == 4'h4) |
                (~SNES_ADDR[22] & (SNES_ADDR[15:13] == 3'b011)));
    k    = lorom ? {SNES_ADDR[23], SNES_ADDR[21]} : SNES_ADDR[21:20];
    // HiROM windows always use the programmed bank; LoROM only in MMC mode.
    bank = (hirom | xxb[k][MODE_BIT]) ? xxb[k][ROM_BANK_W-1:0] : ROM_BANK_W'(k);
    if (SNES_ADDR[22]) off = 24'(SNES_ADDR[19:0]);
    else               off = 24'({sbm, SNES_ADDR[12:0]});
    off        = off & SAVERAM_MASK;
    limit      = LimW'(256) << bwpa;
    writable_d = is_sram_d & (swen | (LimW'(off) >= limit));
    rom_addr_d = '0;
    if (lorom) begin
      rom_addr_d = 24'({bank, SNES_ADDR[20:16], SNES_ADDR[14:0]}) & ROM_MASK;
    end else if (hirom) begin
      rom_addr_d = 24'({bank, SNES_ADDR[19:0]}) & ROM_MASK;
    end else if (is_sram_d) begin
      rom_addr_d = BWRAM_BASE + off;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid_q <= 1'b0;
      rom_addr_q  <= '0;
      is_rom_q    <= 1'b0;
      is_sram_q   <= 1'b0;
      writable_q  <= 1'b0;
    end else begin
      out_valid_q <= req_valid;
      if (req_valid) begin
        rom_addr_q <= rom_addr_d;
        is_rom_q   <= is_rom_d;
        is_sram_q  <= is_sram_d;
        writable_q <= writable_d;
      end
    end
  end

  assign ROM_ADDR    = rom_addr_q;
  assign IS_ROM      = is_rom_q;
  assign IS_SAVERAM  = is_sram_q;
  assign IS_WRITABLE = writable_q;
  assign ROM_HIT     = is_rom_q | writable_q;
  assign out_valid   = out_valid_q;

endmodule
